hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/pipe_pkg.sv | 19 +
 rtl/hazard_scoreboard_pend_counter.sv | 45 ++++
 rtl/hazard_scoreboard.sv | 125 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and default sizing for the issue hazard scoreboard.
package pipe_pkg;

   localparam int REGI_BITS_DEF    = 4;
   localparam int VECT_BITS_DEF    = 2;
   localparam int MAX_INFLIGHT_DEF = 3;
   localparam int STAT_W_DEF       = 16;

   typedef enum logic [1:0] {
      SB_RUN   = 2'd0,
      SB_DRAIN = 2'd1,
      SB_DONE  = 2'd2
   } sb_state_t;

   function automatic int cnt_bits(input int max_inflight);
      return $clog2(max_inflight + 1);
   endfunction

endpackage

// File: rtl/hazard_scoreboard_pend_counter.sv
// Pending-write counter for one register: inc on issue, dec on writeback, flags full/underflow.
// Latency: count updates at the next edge; sat_full_o/busy_o are registered, idle_nxt_o/underflow_o combinational.
module pend_counter
   import pipe_pkg::*;
#(
   parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
   parameter int CNT_W        = cnt_bits(MAX_INFLIGHT_DEF)
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic inc_i,
   input  logic dec_i,
   output logic busy_o,
   output logic sat_full_o,
   output logic underflow_o,
   output logic idle_nxt_o
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // A matching inc/dec pair cancels, so a zero count with both is not an underflow.
   always_comb begin
      cnt_d       = cnt_q;
      underflow_o = 1'b0;
      if (inc_i && !dec_i) begin
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
      end else if (dec_i && !inc_i) begin
         if (cnt_q == '0) underflow_o = 1'b1;
         else             cnt_d = cnt_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign busy_o     = (cnt_q != '0);
   assign sat_full_o = (cnt_q == CNT_MAX);
   assign idle_nxt_o = (cnt_d == '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue scoreboard: stalls decode on RAW hazards or full per-register write depth, drains after END.
// Latency: stall_o/issue_o combinational from registered counters; done_o one cycle after drain completes.
module hazard_scoreboard
   import pipe_pkg::*;
#(
   parameter int REGI_BITS    = REGI_BITS_DEF,
   parameter int VECT_BITS    = VECT_BITS_DEF,
   parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
   parameter int STAT_W       = STAT_W_DEF
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 iss_valid_i,
   input  logic                 iss_end_i,
   input  logic                 flush_i,
   input  logic [REGI_BITS-1:0] src_int_a_i,
   input  logic [REGI_BITS-1:0] src_int_b_i,
   input  logic                 use_int_a_i,
   input  logic                 use_int_b_i,
   input  logic [VECT_BITS-1:0] src_vec_a_i,
   input  logic [VECT_BITS-1:0] src_vec_b_i,
   input  logic                 use_vec_a_i,
   input  logic                 use_vec_b_i,
   input  logic [REGI_BITS-1:0] dst_int_i,
   input  logic                 wr_int_i,
   input  logic [VECT_BITS-1:0] dst_vec_i,
   input  logic                 wr_vec_i,
   input  logic                 wb_int_we_i,
   input  logic [REGI_BITS-1:0] wb_int_dest_i,
   input  logic                 wb_vec_we_i,
   input  logic [VECT_BITS-1:0] wb_vec_dest_i,
   output logic                 stall_o,
   output logic                 issue_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic [STAT_W-1:0]    stall_cnt_o
);

   localparam int NUM_INT = 2 ** REGI_BITS;
   localparam int NUM_VEC = 2 ** VECT_BITS;
   localparam int CNT_W   = cnt_bits(MAX_INFLIGHT);

   sb_state_t state_q, state_d;
   logic      done_q, done_d;
   logic      err_q, err_d;
   logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic [NUM_INT-1:0] int_inc, int_dec, int_busy, int_full, int_unf, int_idle;
   logic [NUM_VEC-1:0] vec_inc, vec_dec, vec_busy, vec_full, vec_unf, vec_idle;

   logic run, raw_hit, waw_full;

   for (genvar i = 0; i < NUM_INT; i++) begin : g_int
      assign int_inc[i] = issue_o & wr_int_i & (dst_int_i == REGI_BITS'(i));
      assign int_dec[i] = wb_int_we_i & (wb_int_dest_i == REGI_BITS'(i));
      pend_counter #(.MAX_INFLIGHT(MAX_INFLIGHT), .CNT_W(CNT_W)) u_cnt (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .inc_i       (int_inc[i]),
         .dec_i       (int_dec[i]),
         .busy_o      (int_busy[i]),
         .sat_full_o  (int_full[i]),
         .underflow_o (int_unf[i]),
         .idle_nxt_o  (int_idle[i])
      );
   end

   for (genvar i = 0; i < NUM_VEC; i++) begin : g_vec
      assign vec_inc[i] = issue_o & wr_vec_i & (dst_vec_i == VECT_BITS'(i));
      assign vec_dec[i] = wb_vec_we_i & (wb_vec_dest_i == VECT_BITS'(i));
      pend_counter #(.MAX_INFLIGHT(MAX_INFLIGHT), .CNT_W(CNT_W)) u_cnt (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .inc_i       (vec_inc[i]),
         .dec_i       (vec_dec[i]),
         .busy_o      (vec_busy[i]),
         .sat_full_o  (vec_full[i]),
         .underflow_o (vec_unf[i]),
         .idle_nxt_o  (vec_idle[i])
      );
   end

   // Hazards look only at registered counts; a writeback landing this cycle frees the source next cycle.
   assign run      = (state_q == SB_RUN);
   assign raw_hit  = (use_int_a_i & int_busy[src_int_a_i]) | (use_int_b_i & int_busy[src_int_b_i])
                   | (use_vec_a_i & vec_busy[src_vec_a_i]) | (use_vec_b_i & vec_busy[src_vec_b_i]);
   assign waw_full = (wr_int_i & int_full[dst_int_i]) | (wr_vec_i & vec_full[dst_vec_i]);
   assign stall_o  = iss_valid_i & ~flush_i & (raw_hit | waw_full | ~run);
   assign issue_o  = iss_valid_i & ~flush_i & ~stall_o & run;

   always_comb begin
      state_d = state_q;
      case (state_q)
         SB_RUN:   if (issue_o && iss_end_i) state_d = SB_DRAIN;
         SB_DRAIN: if ((&int_idle) && (&vec_idle)) state_d = SB_DONE;
         default:  state_d = SB_DONE;
      endcase
   end

   always_comb begin
      done_d      = (state_d == SB_DONE);
      err_d       = err_q | (|int_unf) | (|vec_unf);
      stall_cnt_d = stall_cnt_q;
      if (stall_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STAT_W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= SB_RUN;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         done_q      <= done_d;
         err_q       <= err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign done_o      = done_q;
   assign err_o       = err_q;
   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Vector table plus directed reset/saturation sequences for hazard_scoreboard.
module tb_hazard_scoreboard;

   typedef struct packed {
      logic       v, e, f;
      logic [3:0] sa; logic ua;
      logic [3:0] sb; logic ub;
      logic [1:0] va; logic uva;
      logic [1:0] vb; logic uvb;
      logic [3:0] di; logic wi;
      logic [1:0] dv; logic wv;
      logic       wbi; logic [3:0] wbid;
      logic       wbv; logic [1:0] wbvd;
      logic       xs, xi, xd, xe;
   } vec_t;

   logic clk = 1'b0;
   logic rst_ni;
   logic iss_valid_i, iss_end_i, flush_i;
   logic [3:0] src_int_a_i, src_int_b_i, dst_int_i, wb_int_dest_i;
   logic use_int_a_i, use_int_b_i, use_vec_a_i, use_vec_b_i, wr_int_i, wr_vec_i;
   logic [1:0] src_vec_a_i, src_vec_b_i, dst_vec_i, wb_vec_dest_i;
   logic wb_int_we_i, wb_vec_we_i;
   logic stall_o, issue_o, done_o, err_o;
   logic [15:0] stall_cnt_o;

   int total = 0;
   int bad = 0;
   int step = 0;
   logic [15:0] sc_model = '0;
   logic ex_err = 1'b0;
   logic ex_done = 1'b0;
   vec_t tbl[$];
   vec_t exp_q[$];

   always #5 clk = ~clk;

   hazard_scoreboard dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .iss_valid_i(iss_valid_i), .iss_end_i(iss_end_i), .flush_i(flush_i),
      .src_int_a_i(src_int_a_i), .src_int_b_i(src_int_b_i),
      .use_int_a_i(use_int_a_i), .use_int_b_i(use_int_b_i),
      .src_vec_a_i(src_vec_a_i), .src_vec_b_i(src_vec_b_i),
      .use_vec_a_i(use_vec_a_i), .use_vec_b_i(use_vec_b_i),
      .dst_int_i(dst_int_i), .wr_int_i(wr_int_i),
      .dst_vec_i(dst_vec_i), .wr_vec_i(wr_vec_i),
      .wb_int_we_i(wb_int_we_i), .wb_int_dest_i(wb_int_dest_i),
      .wb_vec_we_i(wb_vec_we_i), .wb_vec_dest_i(wb_vec_dest_i),
      .stall_o(stall_o), .issue_o(issue_o), .done_o(done_o), .err_o(err_o),
      .stall_cnt_o(stall_cnt_o)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s step %0d: got %0h want %0h", nm, step, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      iss_valid_i = t.v;  iss_end_i = t.e;  flush_i = t.f;
      src_int_a_i = t.sa; use_int_a_i = t.ua;
      src_int_b_i = t.sb; use_int_b_i = t.ub;
      src_vec_a_i = t.va; use_vec_a_i = t.uva;
      src_vec_b_i = t.vb; use_vec_b_i = t.uvb;
      dst_int_i = t.di; wr_int_i = t.wi;
      dst_vec_i = t.dv; wr_vec_i = t.wv;
      wb_int_we_i = t.wbi; wb_int_dest_i = t.wbid;
      wb_vec_we_i = t.wbv; wb_vec_dest_i = t.wbvd;
   endtask

   // Expectation goes in the queue when the vector is driven and is checked half a cycle later.
   task automatic apply(input vec_t t);
      vec_t x;
      @(posedge clk); #1;
      drive(t);
      exp_q.push_back(t);
      @(negedge clk);
      x = exp_q.pop_front();
      chk("stall_o", 32'(stall_o), 32'(x.xs));
      chk("issue_o", 32'(issue_o), 32'(x.xi));
      chk("done_o", 32'(done_o), 32'(x.xd));
      chk("err_o", 32'(err_o), 32'(x.xe));
      chk("stall_cnt_o", 32'(stall_cnt_o), 32'(sc_model));
      if (x.xs && sc_model != 16'hFFFF) sc_model = sc_model + 16'd1;
      step++;
   endtask

   function automatic vec_t fin(input vec_t t);
      vec_t r;
      r = t;
      r.xe = ex_err;
      r.xd = ex_done;
      return r;
   endfunction

   initial begin
      vec_t t;
      t = '0;
      drive(t);
      rst_ni = 1'b0;

      // Hazard on r3: stall persists through the writeback cycle itself.
      t='0;                                         tbl.push_back(fin(t));
      t='0; t.v=1; t.di=3; t.wi=1; t.xi=1;          tbl.push_back(fin(t));
      t='0; t.v=1; t.sa=3; t.ua=1; t.xs=1;          tbl.push_back(fin(t));
      t='0; t.v=1; t.sa=3; t.ua=1; t.xs=1;          tbl.push_back(fin(t));
      t='0; t.v=1; t.sa=3; t.ua=1; t.wbi=1; t.wbid=3; t.xs=1; tbl.push_back(fin(t));
      t='0; t.v=1; t.sa=3; t.ua=1; t.xi=1;          tbl.push_back(fin(t));
      t='0; t.v=1; t.di=3; t.wi=1; t.xi=1;          tbl.push_back(fin(t));
      t='0; t.v=1; t.sa=3; t.ua=0; t.sb=3; t.ub=0; t.xi=1; tbl.push_back(fin(t));
      t='0; t.wbi=1; t.wbid=3;                      tbl.push_back(fin(t));
      // v1 write depth saturates at three.
      t='0; t.v=1; t.dv=1; t.wv=1; t.xi=1;          tbl.push_back(fin(t));
      t='0; t.v=1; t.dv=1; t.wv=1; t.xi=1;          tbl.push_back(fin(t));
      t='0; t.v=1; t.dv=1; t.wv=1; t.xi=1;          tbl.push_back(fin(t));
      t='0; t.v=1; t.dv=1; t.wv=1; t.xs=1;          tbl.push_back(fin(t));
      t='0; t.v=1; t.dv=1; t.wv=1; t.wbv=1; t.wbvd=1; t.xs=1; tbl.push_back(fin(t));
      t='0; t.v=1; t.dv=1; t.wv=1; t.xi=1;          tbl.push_back(fin(t));
      t='0; t.v=1; t.va=1; t.uva=0; t.xi=1;         tbl.push_back(fin(t));
      t='0; t.v=1; t.vb=1; t.uvb=1; t.xs=1;         tbl.push_back(fin(t));
      t='0; t.wbv=1; t.wbvd=1;                      tbl.push_back(fin(t));
      t='0; t.wbv=1; t.wbvd=1;                      tbl.push_back(fin(t));
      t='0; t.wbv=1; t.wbvd=1;                      tbl.push_back(fin(t));
      t='0; t.v=1; t.va=1; t.uva=1; t.xi=1;         tbl.push_back(fin(t));
      // r5: simultaneous issue and writeback keep the count at one.
      t='0; t.v=1; t.di=5; t.wi=1; t.xi=1;          tbl.push_back(fin(t));
      t='0; t.v=1; t.di=5; t.wi=1; t.wbi=1; t.wbid=5; t.xi=1; tbl.push_back(fin(t));
      t='0; t.v=1; t.sb=5; t.ub=1; t.xs=1;          tbl.push_back(fin(t));
      t='0; t.wbi=1; t.wbid=5;                      tbl.push_back(fin(t));
      t='0; t.v=1; t.sa=5; t.ua=1; t.xi=1;          tbl.push_back(fin(t));
      t='0; t.wbi=1; t.wbid=7;                      tbl.push_back(fin(t));
      ex_err = 1'b1;
      t='0;                                         tbl.push_back(fin(t));
      t='0;                                         tbl.push_back(fin(t));
      // Flush squashes the write to r2 and masks a hazard on r9.
      t='0; t.v=1; t.f=1; t.di=2; t.wi=1;           tbl.push_back(fin(t));
      t='0; t.v=1; t.sb=2; t.ub=1; t.xi=1;          tbl.push_back(fin(t));
      t='0; t.v=1; t.di=9; t.wi=1; t.xi=1;          tbl.push_back(fin(t));
      t='0; t.v=1; t.f=1; t.sa=9; t.ua=1;           tbl.push_back(fin(t));
      t='0; t.wbi=1; t.wbid=9;                      tbl.push_back(fin(t));
      // END with r1 and v2 outstanding, flush attempted while draining.
      t='0; t.v=1; t.di=1; t.wi=1; t.xi=1;          tbl.push_back(fin(t));
      t='0; t.v=1; t.dv=2; t.wv=1; t.xi=1;          tbl.push_back(fin(t));
      t='0; t.v=1; t.e=1; t.xi=1;                   tbl.push_back(fin(t));
      t='0; t.v=1; t.xs=1;                          tbl.push_back(fin(t));
      t='0; t.v=1; t.f=1;                           tbl.push_back(fin(t));
      t='0; t.wbi=1; t.wbid=1;                      tbl.push_back(fin(t));
      t='0; t.wbv=1; t.wbvd=2;                      tbl.push_back(fin(t));
      ex_done = 1'b1;
      t='0;                                         tbl.push_back(fin(t));
      t='0; t.v=1; t.xs=1;                          tbl.push_back(fin(t));

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst stall_o", 32'(stall_o), 32'd0);
      chk("rst issue_o", 32'(issue_o), 32'd0);
      chk("rst done_o", 32'(done_o), 32'd0);
      chk("rst err_o", 32'(err_o), 32'd0);
      chk("rst stall_cnt_o", 32'(stall_cnt_o), 32'd0);
      rst_ni = 1'b1;

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

      // Reset out of DONE.
      #1; t = '0; drive(t); rst_ni = 1'b0; #1;
      chk("rst2 done_o", 32'(done_o), 32'd0);
      chk("rst2 err_o", 32'(err_o), 32'd0);
      chk("rst2 stall_cnt_o", 32'(stall_cnt_o), 32'd0);
      rst_ni = 1'b1; sc_model = '0;

      // Reset in DRAIN with r6 pending.
      t='0; t.v=1; t.di=6; t.wi=1; t.xi=1; apply(t);
      t='0; t.v=1; t.e=1; t.xi=1;          apply(t);
      t='0; t.v=1; t.sa=6; t.ua=1; t.xs=1; apply(t);
      #1; rst_ni = 1'b0; #1;
      chk("rst3 stall_o", 32'(stall_o), 32'd0);
      chk("rst3 issue_o", 32'(issue_o), 32'd1);
      chk("rst3 stall_cnt_o", 32'(stall_cnt_o), 32'd0);
      rst_ni = 1'b1; sc_model = '0;
      t='0; t.v=1; t.sa=6; t.ua=1; t.xi=1; apply(t);
      t='0; t.v=1; t.di=0; t.wi=1; t.xi=1; apply(t);

      // Hold a RAW stall on r0 long enough to saturate the statistic.
      @(posedge clk); #1;
      t='0; t.v=1; t.sa=0; t.ua=1; drive(t);
      for (int i = 1; i <= 70000; i++) begin
         @(posedge clk);
         if (i == 100) begin
            #1;
            chk("stall_cnt_o mid", 32'(stall_cnt_o), 32'd100);
         end
      end
      @(negedge clk);
      chk("sat stall_o", 32'(stall_o), 32'd1);
      chk("sat stall_cnt_o", 32'(stall_cnt_o), 32'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
